cache_cmd_seq: RTL
==================

Name: cache_cmd_seq

Overview:
Command sequencer sitting directly upstream of the cache. Accepts one host request at a time (write burst, single read, or load burst) plus a write-byte stream, and drives the cache `cmd`/`PID`/`datain`/`datavalid` interface using the cache's `wd`/`outvalid`/`pagefault` handshake. Returns read/load bytes and a completion status to the host. Replaces hand-sequenced bench stimulus with synthesizable control.

Parameters:
FIFO_DEPTH, 4, write-byte FIFO entries (power of 2, ≥2)
LOAD_LEN, 21, bytes returned by one load (cmd=11) transaction
TIMEOUT, 255, max consecutive no-progress cycles before abort (≤255)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
req_valid  input  1  host request strobe
req_ready  output  1  high only in IDLE; request accepted when req_valid&req_ready
req_op  input  2  01 read, 10 write, 11 load; 00 accepted and completes immediately, status ok
req_pid  input  4  process ID for the request
req_len  input  6  write byte count (ignored for read/load)
wbyte  input  8  write data byte
wbyte_valid  input  1  write byte strobe
wbyte_ready  output  1  FIFO not full
cmd  output  2  to cache: 00 idle, 01 read, 10 write, 11 load
PID  output  4  to cache
datain  output  8  to cache
datavalid  output  1  to cache, one-cycle pulse per byte
wd  input  1  from cache: ready for write byte
outvalid  input  1  from cache: dataout valid
dataout  input  8  from cache
pagefault  input  1  from cache
rd_data  output  8  returned byte
rd_valid  output  1  one-cycle pulse per returned byte
done  output  1  one-cycle completion pulse
status  output  2  valid with done, held until next done: 00 ok, 01 pagefault, 10 timeout
busy  output  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE, FIFO empty, timer 0; cmd=00, PID=0, datain=0, datavalid=0, rd_data=0, rd_valid=0, done=0, status=00, busy=0. Mid-transaction reset aborts immediately; no done pulse.
- All outputs are registered except req_ready, wbyte_ready, busy.
- FIFO push on wbyte_valid&wbyte_ready in any state. When full, a push is refused even if a pop occurs in the same cycle. Pop only via write handshake. FIFO is flushed on any abort.
- States: IDLE, WR, RD, LD, DONE.
- IDLE: on accept, latch pid/len and drive PID=req_pid next cycle.
  - op 10 with len>0 → WR, cmd=10.
  - op 01 → RD, cmd=01.
  - op 11 → LD, cmd=11.
  - op 00, or op 10 with len=0 → DONE, status 00.
- WR: cmd held 10. Issue a byte when wd=1 & datavalid=0 & FIFO not empty & sent<len: datain=FIFO head, datavalid=1 for exactly one cycle, pop, sent+1. datavalid is never high on two consecutive cycles. When sent reaches len (last datavalid cycle), → DONE, status 00.
- RD: cmd held 01. On outvalid: rd_data=dataout, rd_valid=1, → DONE, status 00.
- LD: cmd held 11. Each outvalid cycle forwards one byte (rd_valid pulse), cnt+1. On the LOAD_LEN-th byte → DONE, status 00. Bytes beyond that are not forwarded.
- pagefault in RD/LD/WR: → DONE, status 01. pagefault has priority over outvalid and over a write issue in the same cycle; no byte is forwarded or issued.
- Timer: clears on every handshake (datavalid issue, outvalid) and on state entry. Increments each cycle in WR/RD/LD otherwise, including FIFO starvation in WR. Reaching TIMEOUT → DONE, status 10.
- DONE: cmd=00, datavalid=0, done=1 for one cycle, then IDLE. PID holds its last value. cmd therefore returns to 00 the cycle after the completing event.
- status is updated only when done is asserted.

Test Plan:
- Preload 3 bytes A1,B2,C3; req write pid=4 len=3; cache model drives wd high → three datavalid pulses with datain A1,B2,C3 on non-adjacent cycles, cmd=10 PID=4 throughout; then done with status 00 and cmd=00.
- Req read pid=3; outvalid with dataout=5A after 4 cycles → rd_valid once with 5A; done the cycle after the rd_valid pulse; status 00.
- LOAD_LEN=21, req load pid=3; model streams 22 outvalid bytes 00..15 → exactly 21 rd_valid pulses (00..14); done on the cycle after byte 14; cmd=00 before byte 15.
- Load with pagefault and outvalid both high on the 5th byte → 4 bytes forwarded, done with status 01, FIFO flushed.
- Write len=2 with FIFO empty and wd=1 → timer expires at TIMEOUT cycles → done, status 10; no datavalid pulses.
- Push 5 bytes with FIFO_DEPTH=4 → 5th refused (wbyte_ready=0); req_op=00 and write len=0 → done next cycle, status 00; rst low mid-LD → all outputs at reset values immediately.

Source files
------------

// File: rtl/cache_cmd_seq_if.sv
// Cache-side command bus: sequencer drives cmd/PID/datain/datavalid,
// cache answers with wd/outvalid/dataout/pagefault.
interface cache_cmd_seq_if;
  logic [1:0] cmd;
  logic [3:0] PID;
  logic [7:0] datain;
  logic       datavalid;
  logic       wd;
  logic       outvalid;
  logic [7:0] dataout;
  logic       pagefault;

  modport master (
    output cmd, PID, datain, datavalid,
    input  wd, outvalid, dataout, pagefault
  );

  modport slave (
    input  cmd, PID, datain, datavalid,
    output wd, outvalid, dataout, pagefault
  );
endinterface

// File: rtl/cache_cmd_seq.sv
// Host-to-cache command sequencer: runs one write/read/load transaction at a time,
// feeding write bytes from a small FIFO and returning read bytes plus a status.
module cache_cmd_seq #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LOAD_LEN   = 21,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [3:0]            req_pid,
  input  logic [5:0]            req_len,
  input  logic [7:0]            wbyte,
  input  logic                  wbyte_valid,
  output logic                  wbyte_ready,
  cache_cmd_seq_if.master       cif,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic                  done,
  output logic [1:0]            status,
  output logic                  busy
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_LD   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(LOAD_LEN + 1);
  localparam logic [AW:0]   FIFO_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] LD_LAST   = CW'(LOAD_LEN);
  localparam logic [7:0]    TMO       = 8'(TIMEOUT);

  logic [2:0]    state_q, state_d;
  logic [3:0]    pid_q, pid_d;
  logic [5:0]    len_q, len_d, sent_q, sent_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    timer_q, timer_d;
  logic [1:0]    pstat_q, pstat_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [7:0]    datain_q, datain_d;
  logic          datavalid_q, datavalid_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          done_q, done_d;
  logic [1:0]    status_q, status_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;

  logic push, pop, flush, progress, finish;
  logic [1:0] fin_stat;

  assign req_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign wbyte_ready   = (count_q != FIFO_FULL);
  assign cif.cmd       = cmd_q;
  assign cif.PID       = pid_q;
  assign cif.datain    = datain_q;
  assign cif.datavalid = datavalid_q;
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign done          = done_q;
  assign status        = status_q;

  always_comb begin
    state_d     = state_q;
    pid_d       = pid_q;
    len_d       = len_q;
    sent_d      = sent_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    pstat_d     = pstat_q;
    cmd_d       = cmd_q;
    datain_d    = datain_q;
    datavalid_d = 1'b0;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    status_d    = status_q;
    pop         = 1'b0;
    flush       = 1'b0;
    progress    = 1'b0;
    finish      = 1'b0;
    fin_stat    = 2'b00;
    case (state_q)
      S_IDLE: if (req_valid) begin
        pid_d   = req_pid;
        len_d   = req_len;
        sent_d  = '0;
        cnt_d   = '0;
        timer_d = '0;
        case (req_op)
          2'b01: begin state_d = S_RD; cmd_d = 2'b01; end
          2'b11: begin state_d = S_LD; cmd_d = 2'b11; end
          2'b10: if (req_len != '0) begin state_d = S_WR; cmd_d = 2'b10; end
                 else finish = 1'b1;
          default: finish = 1'b1;
        endcase
      end
      S_WR, S_RD, S_LD: begin
        // pagefault wins over any byte movement in the same cycle
        if (cif.pagefault) begin
          finish   = 1'b1;
          fin_stat = 2'b01;
          flush    = 1'b1;
        end else if (state_q == S_WR) begin
          if (cif.wd && !datavalid_q && (count_q != '0) && (sent_q < len_q)) begin
            datain_d    = mem_q[rptr_q];
            datavalid_d = 1'b1;
            pop         = 1'b1;
            progress    = 1'b1;
            sent_d      = sent_q + 1'b1;
            if (sent_d == len_q) finish = 1'b1;
          end
        end else if (cif.outvalid) begin
          rd_data_d  = cif.dataout;
          rd_valid_d = 1'b1;
          progress   = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          if ((state_q == S_RD) || (cnt_d == LD_LAST)) finish = 1'b1;
        end
        if (!cif.pagefault) begin
          if (progress) timer_d = '0;
          else if ((timer_q + 8'd1) == TMO) begin
            finish   = 1'b1;
            fin_stat = 2'b10;
            flush    = 1'b1;
          end else timer_d = timer_q + 8'd1;
        end
      end
      S_DONE: begin
        done_d   = 1'b1;
        status_d = pstat_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (finish) begin
      state_d = S_DONE;
      cmd_d   = 2'b00;
      pstat_d = fin_stat;
    end
  end

  // A full FIFO refuses pushes even when a pop frees a slot this cycle.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    push    = wbyte_valid && wbyte_ready && !flush;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = wbyte;
        wptr_d        = wptr_q + 1'b1;
      end
      if (pop) rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pid_q       <= '0;
      len_q       <= '0;
      sent_q      <= '0;
      cnt_q       <= '0;
      timer_q     <= '0;
      pstat_q     <= '0;
      cmd_q       <= '0;
      datain_q    <= '0;
      datavalid_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      status_q    <= '0;
      mem_q       <= '{default: '0};
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pid_q       <= pid_d;
      len_q       <= len_d;
      sent_q      <= sent_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      pstat_q     <= pstat_d;
      cmd_q       <= cmd_d;
      datain_q    <= datain_d;
      datavalid_q <= datavalid_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      status_q    <= status_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
    end
  end
endmodule
